// File: rtl/shield_scheduler.sv
// Shield power-up sequencer: cooldown, round-robin pickup spawn, held-shield hit
// gating and post-break grace window, with registered sprite/debug outputs.
module shield_scheduler #(
  parameter int unsigned SPAWN_DELAY  = 120,
  parameter int unsigned DESPAWN_TIME = 240,
  parameter int unsigned SHIELD_TIME  = 200,
  parameter int unsigned GRACE_TIME   = 60,
  parameter int unsigned OFFSET       = 64,
  parameter logic [10:0] XPOS0 = 11'd300,
  parameter logic [10:0] XPOS1 = 11'd100,
  parameter logic [10:0] XPOS2 = 11'd700,
  parameter logic [10:0] XPOS3 = 11'd500,
  parameter logic [10:0] YPOS0 = 11'd200,
  parameter logic [10:0] YPOS1 = 11'd500,
  parameter logic [10:0] YPOS2 = 11'd350,
  parameter logic [10:0] YPOS3 = 11'd120
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        game_en,
  input  logic        frame_tick,
  input  logic [9:0]  hit,
  input  logic [10:0] xpos_donkey,
  input  logic [10:0] ypos_donkey,
  output logic [9:0]  hit_pass,
  output logic        is_shielded,
  output logic        shield_visible,
  output logic [10:0] xpos_shield,
  output logic [10:0] ypos_shield,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COOLDOWN  = 3'd1,
    AVAILABLE = 3'd2,
    ACTIVE    = 3'd3,
    GRACE     = 3'd4
  } state_t;

  localparam logic [7:0]  LD_SPAWN   = 8'(SPAWN_DELAY - 1);
  localparam logic [7:0]  LD_DESPAWN = 8'(DESPAWN_TIME - 1);
  localparam logic [7:0]  LD_SHIELD  = 8'(SHIELD_TIME - 1);
  localparam logic [7:0]  LD_GRACE   = 8'(GRACE_TIME - 1);
  localparam logic [11:0] BOX        = 12'(OFFSET);

  state_t      state, state_nx;
  logic [7:0]  cnt, cnt_nx;
  logic [1:0]  slot, slot_nx;
  logic        timeout, pickup;
  logic [11:0] box_x, box_y, don_x, don_y;

  function automatic logic [10:0] slot_x(input logic [1:0] s);
    case (s)
      2'd0:    slot_x = XPOS0;
      2'd1:    slot_x = XPOS1;
      2'd2:    slot_x = XPOS2;
      default: slot_x = XPOS3;
    endcase
  endfunction

  function automatic logic [10:0] slot_y(input logic [1:0] s);
    case (s)
      2'd0:    slot_y = YPOS0;
      2'd1:    slot_y = YPOS1;
      2'd2:    slot_y = YPOS2;
      default: slot_y = YPOS3;
    endcase
  endfunction

  function automatic logic [7:0] load_value(input state_t s);
    case (s)
      COOLDOWN:  load_value = LD_SPAWN;
      AVAILABLE: load_value = LD_DESPAWN;
      ACTIVE:    load_value = LD_SHIELD;
      GRACE:     load_value = LD_GRACE;
      default:   load_value = 8'd0;
    endcase
  endfunction

  // Box test is widened to 12 bits so XPOS+OFFSET near the top of range cannot wrap.
  assign box_x   = {1'b0, slot_x(slot)};
  assign box_y   = {1'b0, slot_y(slot)};
  assign don_x   = {1'b0, xpos_donkey};
  assign don_y   = {1'b0, ypos_donkey};
  assign pickup  = (don_x >= box_x) && (don_x < box_x + BOX) &&
                   (don_y >= box_y) && (don_y < box_y + BOX);
  assign timeout = frame_tick && (cnt == 8'd0);

  always_comb begin
    state_nx = state;
    slot_nx  = slot;
    if (!game_en) begin
      state_nx = IDLE;
      slot_nx  = 2'd0;
    end else begin
      case (state)
        IDLE:      state_nx = COOLDOWN;
        COOLDOWN:  if (timeout) state_nx = AVAILABLE;
        AVAILABLE: begin
          if (pickup) begin
            state_nx = ACTIVE;
          end else if (timeout) begin
            state_nx = COOLDOWN;
            slot_nx  = slot + 2'd1;
          end
        end
        ACTIVE: begin
          if (|hit) begin
            state_nx = GRACE;
          end else if (timeout) begin
            state_nx = COOLDOWN;
            slot_nx  = slot + 2'd1;
          end
        end
        GRACE: begin
          if (timeout) begin
            state_nx = COOLDOWN;
            slot_nx  = slot + 2'd1;
          end
        end
        default:   state_nx = IDLE;
      endcase
    end

    // A tick in the entry cycle is not counted: entry reloads instead of decrementing.
    if (!game_en) begin
      cnt_nx = 8'd0;
    end else if (state_nx != state) begin
      cnt_nx = load_value(state_nx);
    end else if (frame_tick && (cnt != 8'd0)) begin
      cnt_nx = cnt - 8'd1;
    end else begin
      cnt_nx = cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= 8'd0;
      slot           <= 2'd0;
      hit_pass       <= '0;
      is_shielded    <= 1'b0;
      shield_visible <= 1'b0;
      xpos_shield    <= XPOS0;
      ypos_shield    <= YPOS0;
      state_dbg      <= 3'd0;
    end else begin
      state          <= state_nx;
      cnt            <= cnt_nx;
      slot           <= slot_nx;
      // Masking uses the state in force when the hit arrived, so a hit coinciding
      // with pickup still passes and one coinciding with the break is absorbed.
      hit_pass       <= ((state == ACTIVE) || (state == GRACE)) ? '0 : hit;
      is_shielded    <= (state_nx == ACTIVE);
      shield_visible <= (state_nx == AVAILABLE);
      xpos_shield    <= slot_x(slot_nx);
      ypos_shield    <= slot_y(slot_nx);
      state_dbg      <= state_nx;
    end
  end

endmodule

// File: tb/tb_shield_scheduler.sv
// Randomised and directed bench for shield_scheduler with a queue-based scoreboard
// fed by a tick-counting behavioural model.
module tb_shield_scheduler;

  localparam int SD = 3;
  localparam int DT = 2;
  localparam int ST = 4;
  localparam int GT = 3;
  localparam int OFF = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        game_en = 1'b0;
  logic        frame_tick = 1'b0;
  logic [9:0]  hit = '0;
  logic [10:0] xpos_donkey = '0;
  logic [10:0] ypos_donkey = '0;
  logic [9:0]  hit_pass;
  logic        is_shielded;
  logic        shield_visible;
  logic [10:0] xpos_shield;
  logic [10:0] ypos_shield;
  logic [2:0]  state_dbg;

  shield_scheduler #(
    .SPAWN_DELAY(SD), .DESPAWN_TIME(DT), .SHIELD_TIME(ST), .GRACE_TIME(GT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .game_en(game_en), .frame_tick(frame_tick),
    .hit(hit), .xpos_donkey(xpos_donkey), .ypos_donkey(ypos_donkey),
    .hit_pass(hit_pass), .is_shielded(is_shielded), .shield_visible(shield_visible),
    .xpos_shield(xpos_shield), .ypos_shield(ypos_shield), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  hit_pass;
    logic        is_shielded;
    logic        shield_visible;
    logic [10:0] xs;
    logic [10:0] ys;
    logic [2:0]  sd;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  bit   stim_done = 1'b0;

  // Model: phase 0..4 = idle/cooldown/available/active/grace, ticks_left = ticks still owed.
  int m_state = 0;
  int ticks_left = 0;
  int m_slot = 0;

  function automatic int pos_x(input int s);
    case (s) 0: return 300; 1: return 100; 2: return 700; default: return 500; endcase
  endfunction

  function automatic int pos_y(input int s);
    case (s) 0: return 200; 1: return 500; 2: return 350; default: return 120; endcase
  endfunction

  function automatic int phase_len(input int s);
    case (s) 1: return SD; 2: return DT; 3: return ST; 4: return GT; default: return 0; endcase
  endfunction

  function automatic bit in_box(input int x, input int y, input int s);
    return (x >= pos_x(s)) && (x < pos_x(s) + OFF) && (y >= pos_y(s)) && (y < pos_y(s) + OFF);
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Apply the current inputs for one clock: predict the post-edge outputs, queue them.
  task automatic step();
    exp_t e;
    int   nxt, nslot;
    bit   expired, got;
    if (!rst_n) begin
      m_state = 0; ticks_left = 0; m_slot = 0;
      e.hit_pass = '0;
    end else begin
      e.hit_pass = (m_state == 3 || m_state == 4) ? 10'd0 : hit;
      expired = frame_tick && (ticks_left == 1);
      got     = in_box(int'(xpos_donkey), int'(ypos_donkey), m_slot);
      nxt = m_state;
      nslot = m_slot;
      if (!game_en) begin
        nxt = 0; nslot = 0;
      end else begin
        case (m_state)
          0: nxt = 1;
          1: if (expired) nxt = 2;
          2: if (got) nxt = 3;
             else if (expired) begin nxt = 1; nslot = (m_slot + 1) % 4; end
          3: if (hit != 0) nxt = 4;
             else if (expired) begin nxt = 1; nslot = (m_slot + 1) % 4; end
          default: if (expired) begin nxt = 1; nslot = (m_slot + 1) % 4; end
        endcase
      end
      if (nxt != m_state) ticks_left = phase_len(nxt);
      else if (frame_tick && ticks_left > 0) ticks_left--;
      m_state = nxt;
      m_slot = nslot;
    end
    e.is_shielded    = (m_state == 3);
    e.shield_visible = (m_state == 2);
    e.xs = 11'(pos_x(m_slot));
    e.ys = 11'(pos_y(m_slot));
    e.sd = 3'(m_state);
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic run_to(input int target, input int budget);
    int k = 0;
    while (m_state != target && k < budget) begin
      frame_tick = 1'b1;
      step();
      k++;
    end
    frame_tick = 1'b0;
    n_checks++;
    if (m_state != target) begin
      n_fail++;
      $display("FAIL run_to: phase %0d, required %0d within %0d cycles", m_state, target, budget);
    end
  endtask

  // Monitor: every clock after stimulus starts, the DUT presents a full output set.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("hit_pass",       int'(hit_pass),       int'(e.hit_pass));
        check("is_shielded",    int'(is_shielded),    int'(e.is_shielded));
        check("shield_visible", int'(shield_visible), int'(e.shield_visible));
        check("xpos_shield",    int'(xpos_shield),    int'(e.xs));
        check("ypos_shield",    int'(ypos_shield),    int'(e.ys));
        check("state_dbg",      int'(state_dbg),      int'(e.sd));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: stimulus incomplete, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    game_en = 1'b1;
    @(negedge clk);
    repeat (3) step();
    rst_n = 1'b1;
    step();
    run_to(2, 10);

    // Pickup at slot 0 corner, then a shield-absorbed hit and grace masking.
    xpos_donkey = 11'd300; ypos_donkey = 11'd200; step();
    xpos_donkey = 11'd0;   ypos_donkey = 11'd0;   step();
    hit = 10'h004; step();
    hit = 10'h001; step();
    hit = 10'h000;
    run_to(1, 10);
    hit = 10'h001; step();
    hit = 10'h000;

    // Slot 1: pickup at the inclusive far corner on the final tick, with a hit.
    run_to(2, 10);
    frame_tick = 1'b1; step();
    xpos_donkey = 11'd163; ypos_donkey = 11'd563; hit = 10'h200; step();
    xpos_donkey = 11'd0;   ypos_donkey = 11'd0;   hit = 10'h000;
    repeat (ST - 1) step();
    hit = 10'h3ff; step();
    hit = 10'h000; frame_tick = 1'b0;
    run_to(1, 10);

    // Despawn rotation; donkey parked just outside slot 0's box edge.
    xpos_donkey = 11'd364; ypos_donkey = 11'd200;
    for (int i = 0; i < 4; i++) begin
      run_to(2, 10);
      run_to(1, 10);
    end
    run_to(2, 10);
    xpos_donkey = 11'd700; ypos_donkey = 11'd350; step();
    xpos_donkey = 11'd0;   ypos_donkey = 11'd0;
    game_en = 1'b0; hit = 10'h0f0; step();
    step();
    hit = 10'h00f; step();
    game_en = 1'b1; hit = 10'h000; step();
    run_to(2, 10);

    // Mid-round reset.
    rst_n = 1'b0; step(); step();
    rst_n = 1'b1; step();

    for (int i = 0; i < 2500; i++) begin
      rst_n      = ($urandom_range(0, 499) != 0);
      game_en    = ($urandom_range(0, 99) >= 2);
      frame_tick = ($urandom_range(0, 3) == 0);
      hit        = ($urandom_range(0, 9) == 0) ? 10'($urandom) : 10'd0;
      if ($urandom_range(0, 2) == 0) begin
        xpos_donkey = 11'(pos_x(m_slot) - 2 + int'($urandom_range(0, 68)));
        ypos_donkey = 11'(pos_y(m_slot) - 2 + int'($urandom_range(0, 68)));
      end else begin
        xpos_donkey = 11'($urandom);
        ypos_donkey = 11'($urandom);
      end
      step();
    end

    rst_n = 1'b1; game_en = 1'b0; frame_tick = 1'b0; hit = '0;
    @(posedge clk);
    #2;
    check("queue_drained", q.size(), 0);
    stim_done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
